mem_trace_fifo: RTL and testbench
=================================

// Module: mem_trace_fifo
// PURPOSE
//   On-chip consumer of CPU memory-access trace events. Samples instruction-fetch and data-memory
//   access strobes each clock, packs them into tagged entries, buffers them in a FIFO and drains
//   them to a host over a valid/ready port. Sits beside CPU, probing IM/DM ports, replacing file logging.
// PARAMETERS
//   ADDR_W  32  address width of IM and DM ports
//   DEPTH   16  FIFO entries (power of two, >=4)
//   PTR_W   4   log2(DEPTH)
// PORTS
//   clk_i          in   1         clock, all state on rising edge
//   rst_i          in   1         asynchronous active-high reset
//   start_i        in   1         capture enable (same start as CPU)
//   imem_valid_i   in   1         IM fetch event (instr_o != 0)
//   imem_addr_i    in   ADDR_W    IM fetch address
//   dmem_read_i    in   1         DM MemRead strobe
//   dmem_write_i   in   1         DM MemWrite strobe
//   dmem_addr_i    in   ADDR_W    DM access address
//   trace_valid_o  out  1         head entry available
//   trace_data_o   out  ADDR_W+2  {src(1=D,0=I), wr, addr}
//   trace_ready_i  in   1         host accepts head entry
//   level_o        out  PTR_W+1   current entry count, 0..DEPTH
//   overflow_o     out  1         sticky: >=1 event dropped
//   drop_cnt_o     out  16        dropped events, saturates at 16'hFFFF
//   done_o         out  1         capture ended and FIFO fully drained
// BEHAVIOUR
//   Reset: FIFO empty, ptrs 0, level_o=0, trace_valid_o=0, trace_data_o=0, overflow_o=0,
//     drop_cnt_o=0, done_o=0, state=IDLE. Reset mid-operation discards all entries immediately.
//   FSM: IDLE --start_i=1--> CAPTURE --start_i=0--> DRAIN --level==0--> DONE --start_i=1--> CAPTURE.
//     Entering CAPTURE from DONE clears overflow_o and drop_cnt_o; FIFO contents preserved.
//   Events sampled only in CAPTURE (including the cycle start_i falls is NOT sampled).
//   I event: imem_valid_i=1 -> entry {0,0,imem_addr_i}.
//   D event: dmem_read_i|dmem_write_i -> entry {1,dmem_write_i,dmem_addr_i}; both high -> wr=1.
//   Per cycle 0,1 or 2 pushes; when both present order is I then D.
//   Pop: trace_valid_o && trace_ready_i. trace_valid_o = (level!=0); trace_data_o = head entry,
//     first-word-fall-through, stable while valid && !ready.
//   Space this cycle = DEPTH - level + pop. Pushes beyond space dropped, I has priority over D.
//     Each dropped event: drop_cnt_o += 1 (saturating), overflow_o <= 1.
//   level_o next = level + pushes_accepted - pop; never exceeds DEPTH, never underflows.
//   Pointers wrap modulo DEPTH; full when level==DEPTH, empty when level==0.
//   Pop when empty ignored. Push into empty FIFO visible on trace_valid_o the next cycle (latency 1).
//   done_o=1 only in DONE; host may keep popping in DRAIN; DRAIN with ready held low never exits.
// TESTING
//   1 start_i=1, one I event addr 0x0000_0004, ready=1 -> next cycle valid=1, data={0,0,0x4}, popped, level 0.
//   2 Same cycle imem addr 0x8, dmem_write addr 0x40 -> two entries in order {0,0,0x8},{1,1,0x40}, level 2.
//   3 ready=0, 20 I events DEPTH=16 -> level 16, drop_cnt_o=4, overflow_o=1, head = first address.
//   4 Full FIFO, ready=1, I+D event same cycle -> pop 1, I accepted, D dropped, level stays 16, drop_cnt +1.
//   5 start_i 1->0 with 3 entries, ready=1 -> DRAIN 3 cycles, then done_o=1 with level 0; start_i=1 clears drop_cnt.
//   6 rst_i pulsed asynchronously mid-CAPTURE with level 7 -> outputs zero immediately, state IDLE.

Source files
------------

// File: rtl/mem_trace_fifo.sv
// mem_trace_fifo: captures CPU instruction-fetch and data-memory access strobes,
// packs them into tagged entries {src, wr, addr}, buffers them in a small FIFO and
// drains them to a host over a valid/ready port. A four-state controller frames
// capture sessions so the host can tell when a session has been fully drained.
module mem_trace_fifo #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                imem_valid_i,
  input  logic [ADDR_W-1:0]   imem_addr_i,
  input  logic                dmem_read_i,
  input  logic                dmem_write_i,
  input  logic [ADDR_W-1:0]   dmem_addr_i,
  output logic                trace_valid_o,
  output logic [ADDR_W+1:0]   trace_data_o,
  input  logic                trace_ready_i,
  output logic [PTR_W:0]      level_o,
  output logic                overflow_o,
  output logic [15:0]         drop_cnt_o,
  output logic                done_o
);

  localparam int ENTRY_W = ADDR_W + 2;

  // Free-slot arithmetic needs one bit more than level so that DEPTH + pop
  // (a full FIFO that is popped this cycle) does not wrap.
  localparam logic [PTR_W+1:0] DEPTH_X = (PTR_W+2)'(DEPTH);
  localparam logic [PTR_W+1:0] TWO_X   = (PTR_W+2)'(2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  // Entry storage: data only, never reset; validity comes from level.
  logic [ENTRY_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   level;
  logic             overflow;
  logic [15:0]      drop_cnt;

  logic             capture_en;
  logic             i_event;
  logic             d_event;
  logic             pop;
  logic [PTR_W+1:0] space;
  logic             push_i;
  logic             push_d;
  logic [1:0]       push_cnt;
  logic [1:0]       drop_inc;
  logic             clear_stats;
  logic [PTR_W-1:0] d_slot;
  logic [ENTRY_W-1:0] entry_i;
  logic [ENTRY_W-1:0] entry_d;

  // Saturating add for the drop counter; up to two drops may land per cycle.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [1:0] inc);
    logic [16:0] sum;
    sum = {1'b0, a} + {15'b0, inc};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

  // Session controller state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Session controller transitions. DRAIN waits on the current level, so the
  // cycle that pops the last entry is still spent in DRAIN.
  always_comb begin
    state_next  = state;
    clear_stats = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (!start_i) state_next = DRAIN;
      end
      DRAIN: begin
        if (level == '0) state_next = DONE;
      end
      DONE: begin
        if (start_i) begin
          state_next  = CAPTURE;
          clear_stats = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Event qualification and push/drop arbitration. Sampling requires both the
  // CAPTURE state and start_i, so the cycle in which start_i falls is ignored.
  // When space is short, the I event wins over the D event.
  always_comb begin
    capture_en = (state == CAPTURE) && start_i;
    i_event    = capture_en && imem_valid_i;
    d_event    = capture_en && (dmem_read_i || dmem_write_i);
    pop        = (level != '0) && trace_ready_i;
    space      = DEPTH_X - {1'b0, level} + (PTR_W+2)'(pop);
    push_i     = i_event && (space != '0);
    push_d     = d_event && (push_i ? (space >= TWO_X) : (space != '0));
    push_cnt   = {1'b0, push_i} + {1'b0, push_d};
    drop_inc   = {1'b0, i_event && !push_i} + {1'b0, d_event && !push_d};
    d_slot     = wr_ptr + PTR_W'(push_i);
    entry_i    = {1'b0, 1'b0, imem_addr_i};
    entry_d    = {1'b1, dmem_write_i, dmem_addr_i};
  end

  // Entry storage writes: I entry at the write pointer, D entry right behind it.
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= entry_i;
    if (push_d) mem[d_slot] <= entry_d;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_cnt);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      level  <= level + (PTR_W+1)'(push_cnt) - (PTR_W+1)'(pop);
    end
  end

  // Drop statistics: sticky overflow flag plus saturating counter, both cleared
  // when a new session starts from DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_stats) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_inc != 2'd0) begin
      overflow <= 1'b1;
      drop_cnt <= sat_add16(drop_cnt, drop_inc);
    end
  end

  // Host-facing outputs. Head data is forced to zero while empty so that stale
  // storage never shows on the port, including straight after reset.
  always_comb begin
    trace_valid_o = (level != '0);
    trace_data_o  = trace_valid_o ? mem[rd_ptr] : '0;
    level_o       = level;
    overflow_o    = overflow;
    drop_cnt_o    = drop_cnt;
    done_o        = (state == DONE);
  end

endmodule

// File: tb/tb_mem_trace_fifo.sv
// Testbench for mem_trace_fifo: directed scenarios with a queue of expected
// entries that a negedge monitor pops and compares whenever the host pops.
module tb_mem_trace_fifo;

  localparam int ADDR_W = 32;
  localparam int DEPTH  = 16;
  localparam int PTR_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              imem_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic              dmem_read;
  logic              dmem_write;
  logic [ADDR_W-1:0] dmem_addr;
  logic              trace_valid;
  logic [ADDR_W+1:0] trace_data;
  logic              trace_ready;
  logic [PTR_W:0]    level;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic              done;

  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W+1:0] exp_q[$];
  logic [ADDR_W+1:0] mon_exp;

  mem_trace_fifo #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imem_valid_i  (imem_valid),
    .imem_addr_i   (imem_addr),
    .dmem_read_i   (dmem_read),
    .dmem_write_i  (dmem_write),
    .dmem_addr_i   (dmem_addr),
    .trace_valid_o (trace_valid),
    .trace_data_o  (trace_data),
    .trace_ready_i (trace_ready),
    .level_o       (level),
    .overflow_o    (overflow),
    .drop_cnt_o    (drop_cnt),
    .done_o        (done)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: a pop happens at the next rising edge whenever valid and
  // ready are both high mid-cycle; the popped head must match the oldest expected.
  always @(negedge clk) begin
    if (!rst && trace_valid && trace_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL pop_unexpected got=%h required=<queue empty>", trace_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (trace_data !== mon_exp) begin
          n_bad++;
          $display("FAIL pop_data got=%h required=%h", trace_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    imem_valid = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (trace_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%0b required=0", trace_valid); end
    n_cmp++; if (trace_data !== '0) begin n_bad++; $display("FAIL reset_data got=%h required=0", trace_data); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL reset_level got=%0d required=0", level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got=%0b required=0", overflow); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL reset_drop_cnt got=%0d required=0", drop_cnt); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%0b required=0", done); end
  endtask

  task automatic test_single();
    start = 1'b1;
    tick();
    imem_valid = 1'b1; imem_addr = 32'h0000_0004; trace_ready = 1'b1;
    exp_q.push_back({2'b00, 32'h0000_0004});
    tick();
    clr_ev();
    n_cmp++; if (trace_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid got=%0b required=1", trace_valid); end
    n_cmp++; if (trace_data !== {2'b00, 32'h4}) begin n_bad++; $display("FAIL single_data got=%h required=%h", trace_data, {2'b00, 32'h4}); end
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL single_level1 got=%0d required=1", level); end
    tick();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL single_level0 got=%0d required=0", level); end
  endtask

  task automatic test_pair();
    trace_ready = 1'b0;
    imem_valid = 1'b1; imem_addr = 32'h8;
    dmem_write = 1'b1; dmem_addr = 32'h40;
    exp_q.push_back({2'b00, 32'h8});
    exp_q.push_back({2'b11, 32'h40});
    tick();
    clr_ev();
    n_cmp++; if (level !== 5'd2) begin n_bad++; $display("FAIL pair_level got=%0d required=2", level); end
    n_cmp++; if (trace_data !== {2'b00, 32'h8}) begin n_bad++; $display("FAIL pair_head got=%h required=%h", trace_data, {2'b00, 32'h8}); end
    trace_ready = 1'b1;
    tick();
    n_cmp++; if (trace_data !== {2'b11, 32'h40}) begin n_bad++; $display("FAIL pair_second got=%h required=%h", trace_data, {2'b11, 32'h40}); end
    tick();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL pair_empty got=%0d required=0", level); end
  endtask

  // Randomised I/D mixes with the host always ready; at most two pushes and one
  // pop per cycle over ten cycles keeps the FIFO well short of full.
  task automatic test_mixed();
    logic iv, rd, wr;
    logic [31:0] ia, da;
    int cyc;
    trace_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      iv = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ia = $urandom();
      da = $urandom();
      imem_valid = iv; imem_addr = ia;
      dmem_read = rd; dmem_write = wr; dmem_addr = da;
      if (iv) exp_q.push_back({2'b00, ia});
      if (rd || wr) exp_q.push_back({1'b1, wr, da});
      tick();
    end
    clr_ev();
    cyc = 0;
    while (level != 5'd0 && cyc < 40) begin
      tick();
      cyc++;
    end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL mixed_drain_timeout level=%0d required=0", level); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL mixed_leftover got=%0d entries required=0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      imem_valid = 1'b1;
      imem_addr  = 32'h100 + 32'(i * 4);
      if (i < DEPTH) exp_q.push_back({2'b00, 32'h100 + 32'(i * 4)});
      tick();
    end
    clr_ev();
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL ovf_level got=%0d required=16", level); end
    n_cmp++; if (drop_cnt !== 16'd4) begin n_bad++; $display("FAIL ovf_drop_cnt got=%0d required=4", drop_cnt); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got=%0b required=1", overflow); end
    n_cmp++; if (trace_data !== {2'b00, 32'h100}) begin n_bad++; $display("FAIL ovf_head got=%h required=%h", trace_data, {2'b00, 32'h100}); end
  endtask

  task automatic test_full_pop();
    trace_ready = 1'b1;
    imem_valid = 1'b1; imem_addr = 32'h200;
    dmem_read = 1'b1; dmem_addr = 32'h300;
    exp_q.push_back({2'b00, 32'h200});
    tick();
    clr_ev();
    trace_ready = 1'b0;
    n_cmp++; if (level !== 5'd16) begin n_bad++; $display("FAIL fullpop_level got=%0d required=16", level); end
    n_cmp++; if (drop_cnt !== 16'd5) begin n_bad++; $display("FAIL fullpop_drop_cnt got=%0d required=5", drop_cnt); end
    n_cmp++; if (trace_data !== {2'b00, 32'h104}) begin n_bad++; $display("FAIL fullpop_head got=%h required=%h", trace_data, {2'b00, 32'h104}); end
  endtask

  task automatic test_drain();
    trace_ready = 1'b1;
    repeat (13) tick();
    trace_ready = 1'b0;
    n_cmp++; if (level !== 5'd3) begin n_bad++; $display("FAIL drain_pre_level got=%0d required=3", level); end
    // The cycle start falls and the DRAIN cycles carry events that must be ignored.
    start = 1'b0; trace_ready = 1'b1;
    imem_valid = 1'b1; imem_addr = 32'hDEAD_0000;
    dmem_write = 1'b1; dmem_addr = 32'hBEEF_0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (level !== 5'(2 - i)) begin n_bad++; $display("FAIL drain_level%0d got=%0d required=%0d", i, level, 2 - i); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL drain_done%0d got=%0b required=0", i, done); end
    end
    tick();
    clr_ev();
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL drain_done_final got=%0b required=1", done); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL drain_level_final got=%0d required=0", level); end
    n_cmp++; if (drop_cnt !== 16'd5) begin n_bad++; $display("FAIL done_drop_kept got=%0d required=5", drop_cnt); end
    start = 1'b1;
    tick();
    n_cmp++; if (drop_cnt !== 16'd0) begin n_bad++; $display("FAIL restart_drop_cnt got=%0d required=0", drop_cnt); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL restart_overflow got=%0b required=0", overflow); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL restart_done got=%0b required=0", done); end
  endtask

  task automatic test_reset_mid();
    trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      imem_valid = 1'b1;
      imem_addr  = 32'h500 + 32'(i);
      exp_q.push_back({2'b00, 32'h500 + 32'(i)});
      tick();
    end
    clr_ev();
    n_cmp++; if (level !== 5'd7) begin n_bad++; $display("FAIL rstmid_pre_level got=%0d required=7", level); end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (trace_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got=%0b required=0", trace_valid); end
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rstmid_level got=%0d required=0", level); end
    n_cmp++; if (trace_data !== '0) begin n_bad++; $display("FAIL rstmid_data got=%h required=0", trace_data); end
    exp_q.delete();
    tick();
    rst = 1'b0;
    // start is still high: from IDLE the first cycle only moves to CAPTURE.
    imem_valid = 1'b1; imem_addr = 32'h600;
    tick();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rstmid_idle_level got=%0d required=0", level); end
    imem_addr = 32'h604;
    exp_q.push_back({2'b00, 32'h604});
    tick();
    clr_ev();
    n_cmp++; if (level !== 5'd1) begin n_bad++; $display("FAIL rstmid_capture_level got=%0d required=1", level); end
    trace_ready = 1'b1;
    tick();
    n_cmp++; if (level !== 5'd0) begin n_bad++; $display("FAIL rstmid_final_level got=%0d required=0", level); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; trace_ready = 1'b0;
    imem_addr = '0; dmem_addr = '0;
    clr_ev();
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_reset();
    test_single();
    test_pair();
    test_mixed();
    test_overflow();
    test_full_pop();
    test_drain();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
